poly_eval_arbiter: RTL and testbench

Shares one 8-bit polynomial evaluator (result = A*X*X + B*X + C, mod 256) between N_REQ requesters. Each requester presents all four operands in parallel. The arbiter picks a requester round-robin, snapshots its operands, and serialises them onto the evaluator's Go/DataIn load protocol. It then waits for the evaluator's result-valid flag and returns the result to the owning requester. It sits between client blocks and the evaluator instance, and it owns the evaluator's Go and DataIn pins exclusively.

---
 rtl/poly_eval_arbiter.sv | 175 +++++++++++++++++
 tb/tb_poly_eval_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_arbiter.sv
// poly_eval_arbiter
// Round-robin arbiter that shares one 8-bit polynomial evaluator
// (A*X*X + B*X + C mod 256) between N_REQ requesters.
//   clk, reset      : clock, synchronous active-high reset
//   req             : level request per requester
//   op_a/b/c/x      : packed operand bytes, requester i at [8i+7:8i]
//   gnt             : one-hot pulse, operands of that requester captured
//   done            : one-hot pulse, result valid for that requester
//   result          : evaluation result, meaningful only with done
//   busy            : high whenever the FSM is not in IDLE
//   err             : sticky evaluator-timeout flag
//   eval_go         : evaluator Go
//   eval_data_in    : evaluator DataIn
//   eval_result     : evaluator DataResult
//   eval_valid      : evaluator ResultValid
module poly_eval_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] op_a,
  input  logic [8*N_REQ-1:0] op_b,
  input  logic [8*N_REQ-1:0] op_c,
  input  logic [8*N_REQ-1:0] op_x,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [7:0]         result,
  output logic               busy,
  output logic               err,
  output logic               eval_go,
  output logic [7:0]         eval_data_in,
  input  logic [7:0]         eval_result,
  input  logic               eval_valid
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, FAULT} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic [1:0]      idx;
  logic            phase_lo;
  logic [CW-1:0]   cnt;
  logic [7:0]      ops [4];

  logic            found;
  logic [PW-1:0]   pick;
  logic [7:0]      cap_a, cap_b, cap_c, cap_x;
  logic [N_REQ-1:0] sel_oh;

  // First set request at or after the pointer, wrapping.
  always_comb begin
    int unsigned cand;
    logic [PW-1:0] cidx;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr) + i) % N_REQ;
      cidx = PW'(cand);
      if (!found && req[cidx]) begin
        found = 1'b1;
        pick  = cidx;
      end
    end
  end

  // Operand bytes of the candidate requester.
  always_comb begin
    cap_a = '0;
    cap_b = '0;
    cap_c = '0;
    cap_x = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick == PW'(i)) begin
        cap_a = op_a[8*i +: 8];
        cap_b = op_b[8*i +: 8];
        cap_c = op_c[8*i +: 8];
        cap_x = op_x[8*i +: 8];
      end
    end
  end

  // gnt is decoded from the registered state so the grant lands in the
  // same IDLE cycle the request is seen; this keeps one job per 16 cycles.
  always_comb begin
    gnt    = '0;
    sel_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      gnt[i]    = (state == IDLE) && found && (pick == PW'(i));
      sel_oh[i] = (sel == PW'(i));
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      sel          <= '0;
      idx          <= '0;
      phase_lo     <= 1'b0;
      cnt          <= '0;
      for (int unsigned i = 0; i < 4; i++) ops[i] <= '0;
      done         <= '0;
      result       <= '0;
      err          <= 1'b0;
      eval_go      <= 1'b0;
      eval_data_in <= '0;
    end else begin
      done    <= '0;
      eval_go <= 1'b0;
      case (state)
        IDLE: begin
          eval_data_in <= '0;
          if (found) begin
            sel          <= pick;
            ops[0]       <= cap_a;
            ops[1]       <= cap_b;
            ops[2]       <= cap_c;
            ops[3]       <= cap_x;
            ptr          <= (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
            idx          <= '0;
            phase_lo     <= 1'b0;
            state        <= SEND;
            // Outputs are registered, so the first HI beat is set up here.
            eval_go      <= 1'b1;
            eval_data_in <= cap_a;
          end
        end
        SEND: begin
          if (!phase_lo) begin
            phase_lo <= 1'b1;
          end else if (idx == 2'd3) begin
            state        <= WAIT;
            cnt          <= '0;
            eval_data_in <= '0;
          end else begin
            idx          <= idx + 2'd1;
            phase_lo     <= 1'b0;
            eval_go      <= 1'b1;
            eval_data_in <= ops[idx + 2'd1];
          end
        end
        WAIT: begin
          if (eval_valid) begin
            result <= eval_result;
            done   <= sel_oh;
            state  <= DONE;
          end else if (cnt == CW'(TIMEOUT)) begin
            err   <= 1'b1;
            state <= FAULT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        FAULT: begin
          err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval_arbiter.sv
module tb_poly_eval_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] op_a, op_b, op_c, op_x;
  logic [3:0]  gnt, done;
  logic [7:0]  result;
  logic        busy, err, eval_go;
  logic [7:0]  eval_data_in, eval_result;
  logic        eval_valid;

  int n_checks = 0;
  int n_fail   = 0;

  poly_eval_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req(req),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_x(op_x),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .err(err),
    .eval_go(eval_go), .eval_data_in(eval_data_in),
    .eval_result(eval_result), .eval_valid(eval_valid)
  );

  always #5 clk = ~clk;

  // Evaluator stand-in: captures four Go beats, computes for five cycles,
  // raises valid for one cycle. 'dead' suppresses valid entirely.
  logic       dead = 1'b0;
  logic [7:0] ev_ops [3];
  logic [1:0] ev_k;
  logic [2:0] ev_cd;
  logic [7:0] ev_res;
  logic       ev_valid;

  always @(posedge clk) begin
    if (reset) begin
      ev_k     <= '0;
      ev_cd    <= '0;
      ev_valid <= 1'b0;
      ev_res   <= '0;
    end else begin
      ev_valid <= 1'b0;
      if (eval_go) begin
        if (ev_k == 2'd3) begin
          ev_res <= ev_ops[0] * eval_data_in * eval_data_in
                  + ev_ops[1] * eval_data_in + ev_ops[2];
          ev_cd  <= 3'd6;
          ev_k   <= '0;
        end else begin
          ev_ops[ev_k] <= eval_data_in;
          ev_k         <= ev_k + 2'd1;
        end
      end
      if (ev_cd != 0) begin
        ev_cd <= ev_cd - 3'd1;
        if (ev_cd == 3'd1 && !dead) ev_valid <= 1'b1;
      end
    end
  end

  assign eval_valid  = ev_valid;
  assign eval_result = ev_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int who, input logic [7:0] a, b, c, x);
    op_a[8*who +: 8] = a;
    op_b[8*who +: 8] = b;
    op_c[8*who +: 8] = c;
    op_x[8*who +: 8] = x;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_go", eval_go, 0);
    chk("rst_data", eval_data_in, 0);
    reset = 1'b0;
  endtask

  // Full job from the IDLE cycle (cycle 0) through cycle 16.
  task automatic run_job(input int who, input logic [7:0] a, b, c, x, res,
                         input bit mutate, input logic [3:0] extra);
    logic [3:0] oh;
    logic [7:0] opv [4];
    oh     = 4'b0001 << who;
    opv[0] = a; opv[1] = b; opv[2] = c; opv[3] = x;
    chk("idle_busy", busy, 0);
    set_ops(who, a, b, c, x);
    req = oh | extra;
    #1;
    chk("gnt", gnt, oh);
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 1) req = '0;
      if (c == 2 && mutate) begin
        op_a = $urandom; op_b = $urandom; op_c = $urandom; op_x = $urandom;
      end
      if (c <= 8) begin
        chk("send_go", eval_go, c % 2);
        chk("send_data", eval_data_in, opv[(c-1)/2]);
        chk("send_gnt", gnt, 0);
        chk("send_busy", busy, 1);
      end else if (c <= 14) begin
        chk("wait_done", done, 0);
        chk("wait_go", eval_go, 0);
        chk("wait_data", eval_data_in, 0);
      end else if (c == 15) begin
        chk("done", done, oh);
        chk("result", result, res);
        chk("done_busy", busy, 1);
      end else begin
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
      end
    end
  endtask

  typedef struct {
    int         who;
    logic [7:0] a, b, c, x, res;
    bit         mutate;
    logic [3:0] extra;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] cres [4];

  initial begin
    // who, A, B, C, X, expected, mutate operands after capture, extra req bits
    vecs[0] = '{0,   2,   3,   1,   4,  45, 1'b0, 4'b0000};
    vecs[1] = '{0,   5,   7,   9,  10,  67, 1'b0, 4'b0000};
    vecs[2] = '{2,   0,   0,   0,   0,   0, 1'b0, 4'b0001};
    vecs[3] = '{3, 255, 255, 255, 255, 255, 1'b0, 4'b0001};
    vecs[4] = '{1,   1,   0,   0,  16,   0, 1'b0, 4'b1000};
    vecs[5] = '{0,   2,   3,   1,   4,  45, 1'b1, 4'b0000};

    reset = 1'b1;
    req   = '0;
    op_a  = '0; op_b = '0; op_c = '0; op_x = '0;
    do_reset();

    for (int i = 0; i < 6; i++)
      run_job(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x,
              vecs[i].res, vecs[i].mutate, vecs[i].extra);

    // Contention: all four requesting, pointer from reset.
    do_reset();
    set_ops(0, 1, 1, 1, 1);    cres[0] = 3;
    set_ops(1, 2, 0, 0, 3);    cres[1] = 18;
    set_ops(2, 0, 5, 0, 6);    cres[2] = 30;
    set_ops(3, 0, 0, 77, 200); cres[3] = 77;
    req = 4'b1111;
    #1;
    for (int c = 0; c <= 79; c++) begin
      if (c > 0) step();
      if (c == 65) req = '0;
      if (c <= 64)
        chk("cont_gnt", gnt, (c % 16 == 0) ? (4'b0001 << ((c / 16) % 4)) : 4'b0000);
      if (c % 16 == 15) begin
        chk("cont_done", done, 4'b0001 << ((c / 16) % 4));
        chk("cont_result", result, cres[(c / 16) % 4]);
      end else begin
        chk("cont_nodone", done, 0);
      end
    end
    step();
    chk("cont_idle", busy, 0);

    // Reset in the middle of a job on requester 2.
    set_ops(2, 9, 9, 9, 9);
    req = 4'b0100;
    #1;
    chk("mid_gnt", gnt, 4'b0100);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) req = '0;
    end
    reset = 1'b1;
    step();
    chk("mid_gnt0", gnt, 0);
    chk("mid_done0", done, 0);
    chk("mid_result0", result, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_err0", err, 0);
    chk("mid_go0", eval_go, 0);
    chk("mid_data0", eval_data_in, 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("mid_nodone", done, 0);
    end
    run_job(1, 3, 2, 1, 7, 162, 1'b0, 4'b1000);

    // Evaluator never answers: timeout into FAULT.
    do_reset();
    dead = 1'b1;
    set_ops(0, 1, 2, 3, 4);
    req = 4'b0001;
    #1;
    chk("to_gnt", gnt, 4'b0001);
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) req = '0;
      if (c == 24) chk("to_err_pre", err, 0);
      if (c == 25) begin
        chk("to_err", err, 1);
        chk("to_busy", busy, 1);
      end
    end
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("fault_gnt", gnt, 0);
      chk("fault_err", err, 1);
      chk("fault_busy", busy, 1);
      chk("fault_done", done, 0);
    end
    dead = 1'b0;
    do_reset();
    run_job(2, 0, 5, 0, 6, 30, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
